sensor_stimulus_gen: RTL and testbench



---
 rtl/sensor_stimulus_gen.sv | 138 +++++++++++++
 tb/tb_sensor_stimulus_gen.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sensor_stimulus_gen.sv
// Two-wire car-presence sensor stimulus: plays ENTER/LEAVE/FAULT/CLEAR pattern sequences on {a,b}.
// Latency: first pattern one cycle after accept, each pattern held D cycles; accepts only in IDLE.
module sensor_stimulus_gen #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    input  logic [DWELL_W-1:0] dwell,
    output logic               cmd_ready,
    output logic               a,
    output logic               b,
    output logic               done,
    output logic               cmd_err,
    output logic               parked
);

    typedef enum logic [1:0] {IDLE, STEP1, STEP2} state_t;

    localparam logic [1:0] CMD_ENTER = 2'b00;
    localparam logic [1:0] CMD_LEAVE = 2'b01;
    localparam logic [1:0] CMD_FAULT = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [1:0] PAT_EMPTY   = 2'b00;
    localparam logic [1:0] PAT_MOVING  = 2'b10;
    localparam logic [1:0] PAT_PARKED  = 2'b11;
    localparam logic [1:0] PAT_INVALID = 2'b01;

    localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state, state_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [DWELL_W-1:0] reload_q, reload_nxt;
    logic [1:0]         pat2_q, pat2_nxt;
    logic [1:0]         ab_q, ab_nxt;
    logic               err_q, err_nxt;
    logic [DWELL_W-1:0] dwell_m1;
    logic               legal;

    assign cmd_ready = rst_n && (state == IDLE);
    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign cmd_err   = err_q;
    assign parked    = (state == IDLE) && (ab_q == PAT_PARKED);

    // Counter holds D-1 so a dwell of 2^W-1 never needs a wider register.
    assign dwell_m1 = (dwell == '0) ? '0 : dwell - ONE;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        reload_nxt = reload_q;
        pat2_nxt   = pat2_q;
        ab_nxt     = ab_q;
        err_nxt    = 1'b0;
        done       = 1'b0;
        legal      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        CMD_ENTER: legal = (ab_q == PAT_EMPTY);
                        CMD_LEAVE: legal = (ab_q == PAT_PARKED);
                        default:   legal = 1'b1;
                    endcase
                    if (legal) begin
                        cnt_nxt    = dwell_m1;
                        reload_nxt = dwell_m1;
                        case (cmd)
                            CMD_ENTER: begin
                                ab_nxt    = PAT_MOVING;
                                pat2_nxt  = PAT_PARKED;
                                state_nxt = STEP1;
                            end
                            CMD_LEAVE: begin
                                ab_nxt    = PAT_MOVING;
                                pat2_nxt  = PAT_EMPTY;
                                state_nxt = STEP1;
                            end
                            CMD_FAULT: begin
                                ab_nxt    = PAT_INVALID;
                                pat2_nxt  = PAT_EMPTY;
                                state_nxt = STEP1;
                            end
                            CMD_CLEAR: begin
                                ab_nxt    = PAT_EMPTY;
                                pat2_nxt  = PAT_EMPTY;
                                state_nxt = STEP2;
                            end
                            default: ;
                        endcase
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            STEP1: begin
                if (cnt == '0) begin
                    state_nxt = STEP2;
                    ab_nxt    = pat2_q;
                    cnt_nxt   = reload_q;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            STEP2: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            reload_q <= '0;
            pat2_q   <= PAT_EMPTY;
            ab_q     <= PAT_EMPTY;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            reload_q <= reload_nxt;
            pat2_q   <= pat2_nxt;
            ab_q     <= ab_nxt;
            err_q    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_sensor_stimulus_gen.sv
// Bench for sensor_stimulus_gen: directed scenarios then random commands against a queue-based model.
module tb_sensor_stimulus_gen;

    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd = 2'b00;
    logic [DWELL_W-1:0] dwell = '0;
    logic               cmd_ready, a, b, done, cmd_err, parked;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: queue of {a,b} values still to be shown, one entry per cycle.
    logic [1:0] exp_q[$];
    logic [1:0] cur_ab  = 2'b00;
    bit         err_exp = 1'b0;

    sensor_stimulus_gen #(.DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .dwell     (dwell),
        .cmd_ready (cmd_ready),
        .a         (a),
        .b         (b),
        .done      (done),
        .cmd_err   (cmd_err),
        .parked    (parked)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Applies what the DUT's accept edge should do, using the current inputs.
    task automatic model_edge();
        int d;
        if (!rst_n) begin
            exp_q.delete();
            cur_ab  = 2'b00;
            err_exp = 1'b0;
        end else begin
            err_exp = 1'b0;
            if (exp_q.size() > 0) begin
                cur_ab = exp_q.pop_front();
            end else if (cmd_valid) begin
                d = (dwell == 0) ? 1 : int'(dwell);
                case (cmd)
                    2'b00: if (cur_ab == 2'b00) begin
                               repeat (d) exp_q.push_back(2'b10);
                               repeat (d) exp_q.push_back(2'b11);
                           end else err_exp = 1'b1;
                    2'b01: if (cur_ab == 2'b11) begin
                               repeat (d) exp_q.push_back(2'b10);
                               repeat (d) exp_q.push_back(2'b00);
                           end else err_exp = 1'b1;
                    2'b10: begin
                               repeat (d) exp_q.push_back(2'b01);
                               repeat (d) exp_q.push_back(2'b00);
                           end
                    default: repeat (d) exp_q.push_back(2'b00);
                endcase
            end
        end
    endtask

    task automatic check_outputs();
        bit         idle;
        logic [1:0] ab_exp;
        idle   = (exp_q.size() == 0);
        ab_exp = idle ? cur_ab : exp_q[0];
        check_eq("ab",        {30'd0, a, b},  {30'd0, ab_exp});
        check_eq("cmd_ready", {31'd0, cmd_ready}, {31'd0, idle && rst_n});
        check_eq("done",      {31'd0, done},  {31'd0, exp_q.size() == 1});
        check_eq("cmd_err",   {31'd0, cmd_err}, {31'd0, err_exp});
        check_eq("parked",    {31'd0, parked}, {31'd0, idle && (cur_ab == 2'b11)});
        check_eq("done_err_excl", {31'd0, done && cmd_err}, 32'd0);
    endtask

    // Holds the given inputs for n edges, checking outputs after each.
    task automatic run(input logic r, input logic v, input logic [1:0] c,
                       input logic [DWELL_W-1:0] dw, input int n);
        for (int i = 0; i < n; i++) begin
            rst_n = r; cmd_valid = v; cmd = c; dwell = dw;
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end
    endtask

    initial begin
        run(1'b0, 1'b0, 2'b00, 8'd0, 3);
        // ENTER dwell 3, then LEAVE dwell 0 from parked
        run(1'b1, 1'b1, 2'b00, 8'd3, 1);
        run(1'b1, 1'b0, 2'b00, 8'd0, 7);
        run(1'b1, 1'b1, 2'b01, 8'd0, 1);
        run(1'b1, 1'b0, 2'b00, 8'd0, 3);
        // Illegal LEAVE at 00, then illegal ENTER at 11
        run(1'b1, 1'b1, 2'b01, 8'd2, 1);
        run(1'b1, 1'b0, 2'b00, 8'd0, 2);
        run(1'b1, 1'b1, 2'b00, 8'd1, 1);
        run(1'b1, 1'b0, 2'b00, 8'd0, 3);
        run(1'b1, 1'b1, 2'b00, 8'd4, 1);
        run(1'b1, 1'b0, 2'b00, 8'd0, 2);
        // FAULT dwell 2 from 11 with cmd_valid held through busy
        run(1'b1, 1'b1, 2'b10, 8'd2, 6);
        run(1'b1, 1'b0, 2'b00, 8'd0, 6);
        // ENTER dwell 5, reset during second STEP2 cycle, then fresh ENTER
        run(1'b1, 1'b1, 2'b00, 8'd5, 1);
        run(1'b1, 1'b0, 2'b00, 8'd0, 6);
        run(1'b0, 1'b0, 2'b00, 8'd0, 1);
        run(1'b1, 1'b1, 2'b00, 8'd2, 1);
        run(1'b1, 1'b0, 2'b00, 8'd0, 5);
        // CLEAR at maximum dwell
        run(1'b1, 1'b1, 2'b11, 8'd255, 1);
        run(1'b1, 1'b0, 2'b00, 8'd0, 258);
        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic               r, v;
            logic [1:0]         c;
            logic [DWELL_W-1:0] dw;
            r  = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 1) == 1);
            c  = 2'($urandom_range(0, 3));
            dw = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 4));
            run(r, v, c, dw, 1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
